// File: rtl/brc_pkg.sv
// Shared types and constants for the serial branch comparator.
// Nibble-serial A-B is built around one 4-bit carry-lookahead adder.
package brc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } brc_state_e;

    localparam int NIB_BITS  = 4;
    localparam int DEF_WIDTH = 32;

    function automatic int nib_w(input int width);
        return (width / NIB_BITS > 1) ? $clog2(width / NIB_BITS) : 1;
    endfunction

    localparam int NIB_W = nib_w(DEF_WIDTH);

endpackage

// File: rtl/cla_4bit.sv
// Four-bit carry-lookahead adder.
// It supplies the per-cycle carry for the serial comparator.
module cla_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    assign c[0] = cin_i;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign sum_o  = p ^ c[3:0];
    assign cout_o = c[4];

endmodule

// File: rtl/brc_serial_cmp.sv
// Multi-cycle branch comparator: forms A-B one nibble per cycle and
// reports equal / less flags behind a start/done handshake.
module brc_serial_cmp
    import brc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_rs1_data,
    input  logic [WIDTH-1:0] i_rs2_data,
    input  logic             i_br_un,
    output logic             o_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_br_equal,
    output logic             o_br_less
);

    localparam int NIB   = WIDTH / NIB_BITS;
    localparam int CNT_W = nib_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

    brc_state_e state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic un_q, un_d;
    logic sa_q, sa_d;
    logic sb_q, sb_d;
    logic carry_q, carry_d;
    logic eq_q, eq_d;
    logic equal_q, equal_d;
    logic less_q, less_d;

    logic [3:0] unused_sum;
    logic       cout;
    logic       nib_eq;

    cla_4bit u_cla (
        .a_i    (a_sh_q[3:0]),
        .b_i    (b_sh_q[3:0]),
        .cin_i  (carry_q),
        .sum_o  (unused_sum),
        .cout_o (cout)
    );

    assign nib_eq = (a_sh_q[3:0] == ~b_sh_q[3:0]);

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        cnt_d   = cnt_q;
        un_d    = un_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        carry_d = carry_q;
        eq_d    = eq_q;
        equal_d = equal_q;
        less_d  = less_q;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = CALC;
                    a_sh_d  = i_rs1_data;
                    b_sh_d  = ~i_rs2_data;
                    un_d    = i_br_un;
                    sa_d    = i_rs1_data[WIDTH-1];
                    sb_d    = i_rs2_data[WIDTH-1];
                    carry_d = 1'b1;
                    eq_d    = 1'b1;
                    cnt_d   = '0;
                end
            end
            CALC: begin
                carry_d = cout;
                eq_d    = eq_q & nib_eq;
                a_sh_d  = a_sh_q >> NIB_BITS;
                b_sh_d  = b_sh_q >> NIB_BITS;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    // Final carry-out set means A >= B unsigned.
                    state_d = DONE;
                    cnt_d   = '0;
                    equal_d = eq_q & nib_eq;
                    less_d  = un_q ? ~cout
                                   : ((sa_q ^ sb_q) ? sa_q : ~cout);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            cnt_q   <= '0;
            un_q    <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            carry_q <= 1'b0;
            eq_q    <= 1'b0;
            equal_q <= 1'b0;
            less_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            cnt_q   <= cnt_d;
            un_q    <= un_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            carry_q <= carry_d;
            eq_q    <= eq_d;
            equal_q <= equal_d;
            less_q  <= less_d;
        end
    end

    assign o_ready    = (state_q == IDLE);
    assign o_busy     = (state_q != IDLE);
    assign o_done     = (state_q == DONE);
    assign o_br_equal = equal_q;
    assign o_br_less  = less_q;

endmodule

// File: tb/tb_brc_serial_cmp.sv
// Directed and random checks for the serial branch comparator.
// Expected flags come from hand values or a $signed/$unsigned model.
module tb_brc_serial_cmp;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic        i_br_un;
    logic        o_ready;
    logic        o_busy;
    logic        o_done;
    logic        o_br_equal;
    logic        o_br_less;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic prev_eq = 1'b0;
    logic prev_lt = 1'b0;

    brc_serial_cmp #(.WIDTH(32)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_rs1_data (i_rs1_data),
        .i_rs2_data (i_rs2_data),
        .i_br_un    (i_br_un),
        .o_ready    (o_ready),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_br_equal (o_br_equal),
        .o_br_less  (o_br_less)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int c = 0; c < 20 && !o_ready; c++) tick();
        check("ready_wait", o_ready, 1'b1);
    endtask

    task automatic run_cmp(input string tag, input logic [31:0] a,
                           input logic [31:0] b, input logic un,
                           input logic eeq, input logic elt);
        int lat;
        bit got;
        wait_ready();
        i_rs1_data = a;
        i_rs2_data = b;
        i_br_un    = un;
        i_start    = 1'b1;
        tick();
        i_start    = 1'b0;
        i_rs1_data = ~a;
        i_rs2_data = a;
        i_br_un    = ~un;
        lat = 0;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            check({tag, "_hold_eq"}, o_br_equal, prev_eq);
            check({tag, "_hold_lt"}, o_br_less, prev_lt);
            tick();
            lat++;
            if (o_done) begin
                got = 1;
                break;
            end
        end
        check({tag, "_done_seen"}, got, 1'b1);
        check({tag, "_latency"}, lat, 8);
        check({tag, "_eq"}, o_br_equal, eeq);
        check({tag, "_lt"}, o_br_less, elt);
        prev_eq = eeq;
        prev_lt = elt;
        tick();
        check({tag, "_done_width"}, o_done, 1'b0);
        check({tag, "_back_idle"}, o_ready, 1'b1);
    endtask

    logic [31:0] hv_a [3] = '{32'h5, 32'h3, 32'h1234};
    logic [31:0] hv_b [3] = '{32'h3, 32'h5, 32'h1234};
    logic        hv_u [3] = '{1'b0, 1'b1, 1'b0};
    logic        hv_e [3] = '{1'b0, 1'b0, 1'b1};
    logic        hv_l [3] = '{1'b0, 1'b1, 1'b0};

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_prev;
        int acc;
        int lat;
        int dones;
        logic [31:0] ra, rb;
        logic ru, ee, el;

        i_rst = 1'b1;
        i_start = 1'b0;
        i_rs1_data = '0;
        i_rs2_data = '0;
        i_br_un = 1'b0;
        repeat (3) tick();
        i_rst = 1'b0;
        tick();
        check("rst_ready", o_ready, 1'b1);
        check("rst_busy", o_busy, 1'b0);
        check("rst_done", o_done, 1'b0);
        check("rst_eq", o_br_equal, 1'b0);
        check("rst_lt", o_br_less, 1'b0);

        run_cmp("eq_signed", 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);

        // Reset in the fourth CALC cycle.
        i_rs1_data = 32'd5;
        i_rs2_data = 32'd3;
        i_br_un = 1'b0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("midrst_busy_pre", o_busy, 1'b1);
        repeat (3) tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("midrst_ready", o_ready, 1'b1);
        check("midrst_busy", o_busy, 1'b0);
        check("midrst_done", o_done, 1'b0);
        check("midrst_eq", o_br_equal, 1'b0);
        check("midrst_lt", o_br_less, 1'b0);
        prev_eq = 1'b0;
        prev_lt = 1'b0;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (o_done) dones++;
        end
        check("midrst_no_done", dones, 0);

        run_cmp("m1_vs_1_s", 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 1'b1);
        run_cmp("m1_vs_1_u", 32'hFFFFFFFF, 32'h1, 1'b1, 1'b0, 1'b0);
        run_cmp("min_max_s", 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1);
        run_cmp("min_max_u", 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0);
        run_cmp("zero_max_u", 32'h0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1);

        // Start held high; operands scrambled while busy.
        wait_ready();
        i_start = 1'b1;
        acc_prev = 0;
        for (int k = 0; k < 3; k++) begin
            i_rs1_data = hv_a[k];
            i_rs2_data = hv_b[k];
            i_br_un = hv_u[k];
            @(posedge i_clk);
            acc = cyc;
            #1;
            if (k > 0) check("hs_spacing", acc - acc_prev, 10);
            acc_prev = acc;
            lat = 0;
            for (int c = 0; c < 20; c++) begin
                i_rs1_data = $urandom;
                i_rs2_data = $urandom;
                i_br_un = 1'($urandom);
                tick();
                lat++;
                if (o_done) break;
            end
            check("hs_latency", lat, 8);
            check("hs_eq", o_br_equal, hv_e[k]);
            check("hs_lt", o_br_less, hv_l[k]);
            tick();
            check("hs_done_width", o_done, 1'b0);
            check("hs_idle", o_ready, 1'b1);
        end
        i_start = 1'b0;
        prev_eq = hv_e[2];
        prev_lt = hv_l[2];

        for (int i = 0; i < 3000; i++) begin
            ra = $urandom;
            ru = 1'($urandom);
            unique case (i % 4)
                0: rb = $urandom;
                1: rb = ra ^ {28'h0, 4'($urandom_range(15, 1))};
                2: rb = ra ^ {4'($urandom_range(15, 1)), 28'h0};
                default: rb = ra;
            endcase
            ee = (ra == rb);
            el = ru ? (ra < rb) : ($signed(ra) < $signed(rb));
            run_cmp("rand", ra, rb, ru, ee, el);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
